// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared BNN constants, top-level FSM state codes and pooling phase type
package bnn_pkg;

    localparam int IMG_DIM     = 28;
    localparam int POOL_DIM    = IMG_DIM / 2;
    localparam int NUM_OUTPUTS = POOL_DIM * POOL_DIM;

    localparam logic [3:0] LAST_OUT_ROW = 4'(POOL_DIM - 1);

    typedef enum logic [2:0] {
        s_IDLE    = 3'b000,
        s_LOAD    = 3'b001,
        s_LAYER_1 = 3'b010,
        s_LAYER_2 = 3'b011,
        s_LAYER_3 = 3'b100
    } top_state_e;

    typedef enum logic [1:0] {
        PH_EVEN,
        PH_ODD,
        PH_DONE
    } pool_phase_e;

endpackage

// File: rtl/pool_row_2x2.sv
// rtl/pool_row_2x2.sv - combinational 2x2 pooling of a row pair into one pooled row
// POOL_MAJORITY_EN selects a ties-to-one majority vote instead of the OR max-pool.
module pool_row_2x2
    import bnn_pkg::*;
(
    input  logic [IMG_DIM-1:0]  row_even_i,
    input  logic [IMG_DIM-1:0]  row_odd_i,
    output logic [POOL_DIM-1:0] pooled_o
);

    for (genvar j = 0; j < POOL_DIM; j++) begin : g_win
        logic a, b, c, d;
        assign a = row_even_i[2*j];
        assign b = row_even_i[2*j+1];
        assign c = row_odd_i[2*j];
        assign d = row_odd_i[2*j+1];
`ifdef POOL_MAJORITY_EN
        // Any pair of set bits makes the vote, so a 2-2 tie resolves to 1.
        assign pooled_o[j] = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);
`else
        assign pooled_o[j] = a | b | c | d;
`endif
    end

endmodule

// File: rtl/maxpool_flatten_layer.sv
// rtl/maxpool_flatten_layer.sv - row-streamed 2x2 pooling stage packing a flat map for the classifier
// Pooling operator chosen by POOL_MAJORITY_EN inside pool_row_2x2.
module maxpool_flatten_layer
    import bnn_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             state,
    input  logic [IMG_DIM-1:0]     row_in,
    input  logic                   row_valid,
    output logic                   row_ready,
    output logic [NUM_OUTPUTS-1:0] data_out,
    output logic                   layer_2_done
);

    pool_phase_e            phase_q;
    logic [3:0]             out_row_q;
    logic [IMG_DIM-1:0]     row_buf_q;
    logic [NUM_OUTPUTS-1:0] data_out_q;
    logic [NUM_OUTPUTS-1:0] data_out_d;
    logic                   done_q;
    logic                   accept;
    logic [POOL_DIM-1:0]    pooled;
    logic [7:0]             base;

    assign row_ready    = (state == s_LAYER_2) && !done_q;
    assign accept       = row_valid && row_ready;
    assign data_out     = data_out_q;
    assign layer_2_done = done_q;
    assign base         = 8'(out_row_q) * 8'(POOL_DIM);

    pool_row_2x2 u_pool (
        .row_even_i (row_buf_q),
        .row_odd_i  (row_in),
        .pooled_o   (pooled)
    );

    always_comb begin
        data_out_d = data_out_q;
        data_out_d[base +: POOL_DIM] = pooled;
    end

    // Nothing moves without an accept, so leaving s_LAYER_2 simply freezes progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q    <= PH_EVEN;
            out_row_q  <= '0;
            row_buf_q  <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else if (accept) begin
            case (phase_q)
                PH_EVEN: begin
                    row_buf_q <= row_in;
                    phase_q   <= PH_ODD;
                end
                PH_ODD: begin
                    data_out_q <= data_out_d;
                    out_row_q  <= out_row_q + 4'd1;
                    if (out_row_q == LAST_OUT_ROW) begin
                        phase_q <= PH_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= PH_EVEN;
                    end
                end
                default: phase_q <= PH_DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_flatten_layer.sv
// tb/tb_maxpool_flatten_layer.sv - directed self-checking bench for maxpool_flatten_layer
module tb_maxpool_flatten_layer;
    import bnn_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [2:0]             state;
    logic [IMG_DIM-1:0]     row_in;
    logic                   row_valid;
    logic                   row_ready;
    logic [NUM_OUTPUTS-1:0] data_out;
    logic                   layer_2_done;

    int checks = 0;
    int errors = 0;
    logic [IMG_DIM-1:0] frame [IMG_DIM];

    maxpool_flatten_layer dut (
        .clock        (clock),
        .reset        (reset),
        .state        (state),
        .row_in       (row_in),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .data_out     (data_out),
        .layer_2_done (layer_2_done)
    );

    always #5 clock = ~clock;

    function automatic logic pbit(input logic a, input logic b, input logic c, input logic d);
`ifdef POOL_MAJORITY_EN
        return (int'(a) + int'(b) + int'(c) + int'(d)) >= 2;
`else
        return a | b | c | d;
`endif
    endfunction

    // Expected map after n rows of frame have been accepted.
    function automatic logic [NUM_OUTPUTS-1:0] model(input int n);
        logic [NUM_OUTPUTS-1:0] res;
        res = '0;
        for (int k = 0; k < POOL_DIM; k++)
            if (2*k+1 < n)
                for (int j = 0; j < POOL_DIM; j++)
                    res[k*POOL_DIM+j] = pbit(frame[2*k][2*j], frame[2*k][2*j+1],
                                             frame[2*k+1][2*j], frame[2*k+1][2*j+1]);
        return res;
    endfunction

    task automatic do_reset();
        reset = 1'b0; state = s_IDLE; row_valid = 1'b0; row_in = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic stream(input int nrows, input bit gappy, input bit stall);
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit stalled = 1'b0;
        state = s_LAYER_2;
        while (idx < nrows && cyc < 400) begin
            row_in    = frame[idx];
            row_valid = gappy ? cyc[0] : 1'b1;
            if (stall && idx == 11 && !stalled) begin
                stalled = 1'b1;
                state = s_LAYER_1;
                row_valid = 1'b1;
                repeat (5) begin
                    #1;
                    checks++;
                    if (row_ready !== 1'b0) begin
                        errors++; $display("FAIL stall_ready: got %b want 0", row_ready);
                    end
                    @(posedge clock); #1;
                    checks++;
                    if (data_out !== model(idx)) begin
                        errors++; $display("FAIL stall_freeze: got %h want %h", data_out, model(idx));
                    end
                end
                state = s_LAYER_2;
            end
            #1;
            acc = row_valid && row_ready;
            @(posedge clock); #1;
            cyc++;
            if (acc) idx++;
            checks++;
            if (data_out !== model(idx)) begin
                errors++; $display("FAIL data_row%0d: got %h want %h", idx, data_out, model(idx));
            end
            checks++;
            if (layer_2_done !== (idx == IMG_DIM)) begin
                errors++; $display("FAIL done_row%0d: got %b want %b", idx, layer_2_done, idx == IMG_DIM);
            end
        end
        row_valid = 1'b0;
        checks++;
        if (idx < nrows) begin
            errors++; $display("FAIL stream_timeout: got %0d rows want %0d", idx, nrows);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        checks++;
        if (layer_2_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", layer_2_done); end
        checks++;
        if (row_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", row_ready); end
        state = s_LAYER_2;
        #1;
        checks++;
        if (row_ready !== 1'b1) begin errors++; $display("FAIL ready_layer2: got %b want 1", row_ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_all_ones();
        logic [NUM_OUTPUTS-1:0] held;
        for (int i = 0; i < IMG_DIM; i++) frame[i] = '1;
        do_reset();
        stream(IMG_DIM, 1'b0, 1'b0);
        held = {NUM_OUTPUTS{1'b1}};
        checks++;
        if (data_out !== held) begin errors++; $display("FAIL ones_data: got %h want %h", data_out, held); end
        checks++;
        if (row_ready !== 1'b0) begin errors++; $display("FAIL ones_ready: got %b want 0", row_ready); end
        row_in = '0; row_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1 row_valid = 1'b0;
        checks++;
        if (data_out !== held || layer_2_done !== 1'b1) begin
            errors++; $display("FAIL done_hold: got %h/%b want %h/1", data_out, layer_2_done, held);
        end
    endtask

    task automatic test_first_corner();
        logic [NUM_OUTPUTS-1:0] want;
        for (int i = 0; i < IMG_DIM; i++) frame[i] = '0;
        frame[0] = 28'h0000001;
        do_reset();
        stream(IMG_DIM, 1'b0, 1'b0);
`ifdef POOL_MAJORITY_EN
        want = '0;
`else
        want = 196'h1;
`endif
        checks++;
        if (data_out !== want) begin errors++; $display("FAIL first_corner: got %h want %h", data_out, want); end
    endtask

    task automatic test_last_corner();
        logic [NUM_OUTPUTS-1:0] want;
        for (int i = 0; i < IMG_DIM; i++) frame[i] = '0;
        frame[26] = 28'h8000000;
        frame[27] = 28'h8000000;
        do_reset();
        stream(IMG_DIM, 1'b0, 1'b0);
        want = '0;
        want[195] = 1'b1;
        checks++;
        if (data_out !== want) begin errors++; $display("FAIL last_corner: got %h want %h", data_out, want); end
    endtask

    task automatic test_gaps_and_stall();
        for (int i = 0; i < IMG_DIM; i++) frame[i] = 28'h5A3C0F1 ^ (28'(i) * 28'h0123457);
        do_reset();
        stream(IMG_DIM, 1'b1, 1'b1);
        checks++;
        if (data_out !== model(IMG_DIM)) begin
            errors++; $display("FAIL gap_final: got %h want %h", data_out, model(IMG_DIM));
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < IMG_DIM; i++) frame[i] = '1;
        do_reset();
        stream(15, 1'b0, 1'b0);
        do_reset();
        checks++;
        if (data_out !== '0 || layer_2_done !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: got %h/%b want 0/0", data_out, layer_2_done);
        end
        for (int i = 0; i < IMG_DIM; i++) frame[i] = 28'h0C30C30 >> (i % 5);
        stream(IMG_DIM, 1'b0, 1'b0);
        checks++;
        if (data_out !== model(IMG_DIM)) begin
            errors++; $display("FAIL fresh_frame: got %h want %h", data_out, model(IMG_DIM));
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_first_corner();
        test_last_corner();
        test_gaps_and_stall();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
